// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for InstROM: holds the PC, applies halt/jump/branch
// redirects from decode, and tracks a start/done run with a cycle counter.
module fetch_sequencer #(
  parameter int PC_W      = 8,
  parameter int LUT_DEPTH = 16,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = $clog2(LUT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_pc,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             jump_en,
  input  logic [IDX_W-1:0] jump_idx,
  input  logic             branch_en,
  input  logic [PC_W-1:0]  branch_off,
  input  logic             lut_we,
  input  logic [IDX_W-1:0] lut_widx,
  input  logic [PC_W-1:0]  lut_wdata,
  output logic [PC_W-1:0]  PC,
  output logic             fetch_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [PC_W-1:0]  target_lut [LUT_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      PC          <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      PC          <= pc_nxt;
      cycle_count <= count_nxt;
    end
  end

  // Same-cycle jump reads the pre-write entry because the read is combinational off the register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        target_lut[i] <= '0;
      end
    end else if (lut_we) begin
      target_lut[lut_widx] <= lut_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    count_nxt = cycle_count;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = start_pc;
          count_nxt = '0;
        end
      end
      RUN: begin
        if (cycle_count != {CNT_W{1'b1}}) begin
          count_nxt = cycle_count + 1'b1;
        end
        // Width-PC_W addition wraps, which equals adding the sign-extended offset mod 2^PC_W.
        if (!stall) begin
          if (halt_req) begin
            state_nxt = DONE;
          end else if (jump_en) begin
            pc_nxt = target_lut[jump_idx];
          end else if (branch_en) begin
            pc_nxt = PC + branch_off;
          end else begin
            pc_nxt = PC + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy        = (state == RUN);
  assign fetch_valid = (state == RUN);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: start/run/halt, redirect
// priority, table read-before-write, wrap, stall, saturation and async reset.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  start_pc;
  logic        stall;
  logic        halt_req;
  logic        jump_en;
  logic [3:0]  jump_idx;
  logic        branch_en;
  logic [7:0]  branch_off;
  logic        lut_we;
  logic [3:0]  lut_widx;
  logic [7:0]  lut_wdata;
  logic [7:0]  PC;
  logic        fetch_valid;
  logic        busy;
  logic        done;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.PC_W(8), .LUT_DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .stall(stall), .halt_req(halt_req), .jump_en(jump_en), .jump_idx(jump_idx),
    .branch_en(branch_en), .branch_off(branch_off), .lut_we(lut_we),
    .lut_widx(lut_widx), .lut_wdata(lut_wdata), .PC(PC),
    .fetch_valid(fetch_valid), .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of decode inputs, lets one rising edge pass, samples 1ns later.
  task automatic applyStimulus(input logic s, input logic [7:0] spc, input logic st,
                               input logic h, input logic j, input logic [3:0] ji,
                               input logic b, input logic [7:0] bo);
    start = s; start_pc = spc; stall = st; halt_req = h;
    jump_en = j; jump_idx = ji; branch_en = b; branch_off = bo;
    @(posedge clk);
    #1;
    start = 1'b0; stall = 1'b0; halt_req = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
    lut_we = 1'b0;
  endtask

  task automatic lutWrite(input logic [3:0] idx, input logic [7:0] data);
    lut_we = 1'b1; lut_widx = idx; lut_wdata = data;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [7:0] exp_pc,
                            input logic exp_busy, input logic exp_done,
                            input logic [15:0] exp_cnt);
    checkOutput({tag, "_pc"}, {8'h00, PC}, {8'h00, exp_pc});
    checkOutput({tag, "_busy"}, {15'h0, busy}, {15'h0, exp_busy});
    checkOutput({tag, "_valid"}, {15'h0, fetch_valid}, {15'h0, exp_busy});
    checkOutput({tag, "_done"}, {15'h0, done}, {15'h0, exp_done});
    checkOutput({tag, "_cnt"}, cycle_count, exp_cnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_pc = 8'h00; stall = 1'b0; halt_req = 1'b0;
    jump_en = 1'b0; jump_idx = 4'h0; branch_en = 1'b0; branch_off = 8'h00;
    lut_we = 1'b0; lut_widx = 4'h0; lut_wdata = 8'h00;
    #1;
    checkState("reset", 8'h00, 1'b0, 1'b0, 16'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 0, 4'h0, 0, 8'h00);
    checkState("idle_hold", 8'h00, 1'b0, 1'b0, 16'd0);

    // Start at 0x10, five plain increments, then halt.
    applyStimulus(1, 8'h10, 0, 0, 0, 4'h0, 0, 8'h00);
    checkState("start", 8'h10, 1'b1, 1'b0, 16'd0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 8'h00, 0, 0, 0, 4'h0, 0, 8'h00);
      checkOutput("inc_pc", {8'h00, PC}, 16'h0010 + 16'(k));
      checkOutput("inc_cnt", cycle_count, 16'(k));
    end
    applyStimulus(0, 8'h00, 0, 1, 0, 4'h0, 0, 8'h00);
    checkState("halt", 8'h15, 1'b0, 1'b1, 16'd6);
    applyStimulus(0, 8'h00, 0, 0, 0, 4'h0, 0, 8'h00);
    checkState("done_hold", 8'h15, 1'b0, 1'b1, 16'd6);

    // Table write in DONE, then jump beats branch, and same-cycle write reads old entry.
    lutWrite(4'h3, 8'h80);
    applyStimulus(0, 8'h00, 0, 0, 0, 4'h0, 0, 8'h00);
    applyStimulus(1, 8'h20, 0, 0, 0, 4'h0, 0, 8'h00);
    checkState("start2", 8'h20, 1'b1, 1'b0, 16'd0);
    applyStimulus(0, 8'h00, 0, 0, 1, 4'h3, 1, 8'h05);
    checkOutput("jump_wins", {8'h00, PC}, 16'h0080);
    lutWrite(4'h3, 8'h90);
    applyStimulus(0, 8'h00, 0, 0, 1, 4'h3, 0, 8'h00);
    checkOutput("jump_old_entry", {8'h00, PC}, 16'h0080);
    applyStimulus(0, 8'h00, 0, 0, 1, 4'h3, 0, 8'h00);
    checkOutput("jump_new_entry", {8'h00, PC}, 16'h0090);

    // Start during RUN is ignored.
    applyStimulus(1, 8'h77, 0, 0, 0, 4'h0, 0, 8'h00);
    checkState("start_in_run", 8'h91, 1'b1, 1'b0, 16'd4);

    // Branch wrap below zero and above 255.
    lutWrite(4'h5, 8'h03);
    applyStimulus(0, 8'h00, 0, 0, 0, 4'h0, 0, 8'h00);
    checkOutput("write_inc_pc", {8'h00, PC}, 16'h0092);
    applyStimulus(0, 8'h00, 0, 0, 1, 4'h5, 0, 8'h00);
    checkOutput("jump_to_3", {8'h00, PC}, 16'h0003);
    applyStimulus(0, 8'h00, 0, 0, 0, 4'h0, 1, 8'hFB);
    checkOutput("branch_neg_wrap", {8'h00, PC}, 16'h00FE);
    applyStimulus(0, 8'h00, 0, 0, 0, 4'h0, 1, 8'h0A);
    checkOutput("branch_pos_wrap", {8'h00, PC}, 16'h0008);
    lutWrite(4'h7, 8'h22);
    applyStimulus(0, 8'h00, 0, 1, 0, 4'h0, 0, 8'h00);
    checkState("halt2", 8'h08, 1'b0, 1'b1, 16'd9);

    // Back-to-back start from the first DONE cycle, increment wrap 0xFF -> 0x00.
    applyStimulus(1, 8'hFF, 0, 0, 0, 4'h0, 0, 8'h00);
    checkState("start_ff", 8'hFF, 1'b1, 1'b0, 16'd0);
    applyStimulus(0, 8'h00, 0, 0, 0, 4'h0, 0, 8'h00);
    checkOutput("inc_wrap", {8'h00, PC}, 16'h0000);

    // Stall freezes PC and masks halt/jump while the counter keeps running.
    applyStimulus(0, 8'h00, 0, 0, 1, 4'h7, 0, 8'h00);
    checkState("jump_22", 8'h22, 1'b1, 1'b0, 16'd2);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 8'h00, 1, 1, 1, 4'h3, 1, 8'h10);
      checkState("stall", 8'h22, 1'b1, 1'b0, 16'd2 + 16'(k));
    end
    applyStimulus(0, 8'h00, 0, 1, 0, 4'h0, 0, 8'h00);
    checkState("stall_release", 8'h22, 1'b0, 1'b1, 16'd6);

    // Counter saturation at 0xFFFF.
    applyStimulus(1, 8'h00, 0, 0, 0, 4'h0, 0, 8'h00);
    for (int k = 0; k < 65534; k++) begin
      @(posedge clk);
    end
    #1;
    checkOutput("cnt_fffe", cycle_count, 16'hFFFE);
    applyStimulus(0, 8'h00, 0, 0, 0, 4'h0, 0, 8'h00);
    checkOutput("cnt_ffff", cycle_count, 16'hFFFF);
    applyStimulus(0, 8'h00, 0, 0, 0, 4'h0, 0, 8'h00);
    checkOutput("cnt_sat", cycle_count, 16'hFFFF);
    applyStimulus(0, 8'h00, 0, 1, 0, 4'h0, 0, 8'h00);
    checkState("sat_done", PC, 1'b0, 1'b1, 16'hFFFF);

    // Async reset mid-RUN with a pending jump, then table is cleared.
    applyStimulus(1, 8'h40, 0, 0, 0, 4'h0, 0, 8'h00);
    checkState("start_40", 8'h40, 1'b1, 1'b0, 16'd0);
    jump_en = 1'b1; jump_idx = 4'h7;
    #2;
    reset = 1'b1;
    #1;
    checkState("async_reset", 8'h00, 1'b0, 1'b0, 16'd0);
    #1;
    reset = 1'b0;
    jump_en = 1'b0;
    applyStimulus(1, 8'h50, 0, 0, 0, 4'h0, 0, 8'h00);
    checkState("start_50", 8'h50, 1'b1, 1'b0, 16'd0);
    applyStimulus(0, 8'h00, 0, 0, 1, 4'h7, 0, 8'h00);
    checkOutput("lut_cleared7", {8'h00, PC}, 16'h0000);
    applyStimulus(0, 8'h00, 0, 0, 1, 4'h3, 0, 8'h00);
    checkOutput("lut_cleared3", {8'h00, PC}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer feeding the 8-bit `PC` input of `InstROM`. It holds the architectural PC, advances it each cycle, and applies halt, jump and branch redirects from the decode stage. Jump targets come from a small writable target table. A start/done handshake and a run-cycle counter let the top-level test harness launch a program and measure it.

## Interface
Parameters:
- `PC_W`, 8: PC width; matches the `InstROM` address width.
- `LUT_DEPTH`, 16: number of jump-target entries. The index width is log2(`LUT_DEPTH`) = 4.
- `CNT_W`, 16: cycle counter width.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that launches a program.
- `start_pc`  in  8  first PC of the program; sampled on `start`.
- `stall`  in  1  freeze the PC for this cycle.
- `halt_req`  in  1  decoded halt instruction.
- `jump_en`  in  1  absolute jump through the target table.
- `jump_idx`  in  4  target-table index for the jump.
- `branch_en`  in  1  taken PC-relative branch.
- `branch_off`  in  8  signed two's-complement branch offset.
- `lut_we`  in  1  target-table write enable.
- `lut_widx`  in  4  target-table write index.
- `lut_wdata`  in  8  target-table write data.
- `PC`  out  8  registered program counter; drives `InstROM.PC`.
- `fetch_valid`  out  1  high while in RUN; qualifies `PC` and the ROM's `mach_code`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high in DONE.
- `cycle_count`  out  16  number of RUN cycles in the current or last program.

## Operation
- States: IDLE, RUN, DONE. `fetch_valid` = `busy` = (state==RUN). `done` = (state==DONE).
- Reset values: state IDLE, `PC`=0, `cycle_count`=0, all target-table entries 0, `fetch_valid`/`busy`/`done`=0.
- IDLE or DONE, with `start`=1:
  - `PC`<=`start_pc`, `cycle_count`<=0, next state RUN.
- IDLE or DONE, with `start`=0: all state holds.
- `start` during RUN is ignored.
- RUN cycle with `stall`=1:
  - `PC` holds.
  - `halt_req`, `jump_en` and `branch_en` are all ignored.
- RUN cycle with `stall`=0, fixed priority:
  - `halt_req`: `PC` holds, next state DONE.
  - else `jump_en`: `PC`<=table[`jump_idx`].
  - else `branch_en`: `PC`<=(`PC` + sign-extended `branch_off`) mod 256.
  - else: `PC`<=(`PC`+1) mod 256.
- Wrap-around:
  - Increment from 255 gives 0.
  - Branch from 3 with offset 0xFB (−5) gives 254.
  - Branch from 250 with offset 0x0A gives 4.
  - No error or flag is raised on wrap.
- `cycle_count` increments by 1 in every RUN cycle, including stall cycles and the halt cycle.
  - It saturates at 0xFFFF.
  - It holds in IDLE and DONE and stays readable after `done`.
- Target table:
  - Written on the clock edge when `lut_we`=1; writes are allowed in any state.
  - A jump and a write to the same index in the same cycle: the jump uses the old entry.
  - Table contents survive `start`; they are cleared only by `reset`.
- `reset` asserted mid-RUN immediately forces all reset values. A pending redirect in that cycle is discarded.

## Timing
- `PC` is a register. `InstROM` is combinational, so `mach_code` for `PC` is valid in the same cycle. Decode drives `halt_req`/`jump_en`/`branch_en` combinationally from that `mach_code`, and they take effect at the next edge.
- Start latency: `start` high at edge N gives `PC`=`start_pc` and `fetch_valid`=1 after edge N.
- Redirect latency: one cycle. The instruction at the redirect target is presented in the cycle after the jump or branch cycle. No delay slot.
- Halt: a halt decoded in cycle N gives `done`=1 after edge N. `PC` stays at the halt instruction's address.
- Back-to-back programs: `start` in the first DONE cycle is legal and re-enters RUN after one edge.

## Test plan
- Reset, then `start` with `start_pc`=0x10, 5 unstalled cycles, then `halt_req` → `PC` sequence 0x10..0x15. `done`=1 with `PC`=0x15 and `cycle_count`=6.
- `lut_we` idx 3 = 0x80, then in RUN assert `jump_en` idx 3 together with `branch_en` → next `PC`=0x80 (jump wins). Same cycle write idx 3 = 0x90 with jump idx 3 → `PC`=0x80 (old entry).
- Branch from `PC`=0x03 with offset 0xFB → `PC`=0xFE. Start at 0xFF with no redirect → next `PC`=0x00.
- `stall`=1 for 3 cycles with `halt_req`=1 at `PC`=0x22 → `PC` stays 0x22, state remains RUN, `cycle_count` +3. Release stall → DONE.
- `reset` pulsed mid-RUN at `PC`=0x40 → `PC`=0, `busy`=0, `done`=0, `cycle_count`=0 and table cleared, all without waiting for a clock edge. A subsequent jump reads 0x00.
- `start` asserted during RUN → ignored, `PC` continues incrementing. Drive the ROM with `mach_code.txt` and check that `mach_code` matches the file's row at each `PC` visited.
